// File: rtl/t08_mc_control_fsm.sv
// Multi-cycle RV32I control sequencer: latches the fetched word into IR and steps
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with req/ack handshakes; illegal ops and memory timeouts trap.
//   state     | meaning
//   FETCH     | fetch_req high, wait for instr_ack, load IR
//   DECODE    | field decode of IR, illegal encodings go to TRAP
//   EXECUTE   | ALU op, register reads, jump/branch strobes
//   MEMORY    | load/store request held until mem_ack or timeout
//   WRITEBACK | register write strobe and PC advance
//   TRAP      | sticky error, left only through reset
module t08_mc_control_fsm #(
    parameter int XLEN        = 32,
    parameter int ALU_CTRL_W  = 6,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_ack,
    input  logic [31:0]           instr_in,
    input  logic                  mem_ack,
    output logic                  fetch_req,
    output logic                  read,
    output logic                  write,
    output logic [2:0]            funct3,
    output logic [4:0]            reg1,
    output logic [4:0]            reg2,
    output logic [4:0]            regd,
    output logic                  en_read_1,
    output logic                  en_read_2,
    output logic                  en_write,
    output logic [1:0]            data_in_control,
    output logic [XLEN-1:0]       immediate,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  jump,
    output logic                  branch_en,
    output logic                  pc_en,
    output logic                  trap,
    output logic [2:0]            state
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] F7_ALT    = 7'h20;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    state_t           st;
    logic [31:0]      ir;
    logic [CNT_W-1:0] cnt;

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    assign op = ir[6:0];
    assign f3 = ir[14:12];
    assign f7 = ir[31:25];

    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;
    assign imm_i = ir[31:20];
    assign imm_s = {ir[31:25], ir[11:7]};
    assign imm_b = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'h000};
    assign imm_j = {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    int              d_code;
    logic            d_ill, use_rs1, use_rs2, wr_rd, is_load, is_store, is_jump, is_branch;
    logic [1:0]      d_dic;
    logic [XLEN-1:0] d_imm;
    logic            d_wr;

    always_comb begin
        d_code = 0;      d_ill = 1'b0;    use_rs1 = 1'b0;   use_rs2 = 1'b0;
        wr_rd = 1'b0;    is_load = 1'b0;  is_store = 1'b0;  is_jump = 1'b0;
        is_branch = 1'b0; d_dic = 2'd0;   d_imm = '0;
        case (op)
            OP_R: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1;
                case (f3)
                    3'd0:    d_code = (f7 == F7_ALT) ? 2 : 1;
                    3'd1:    d_code = 3;
                    3'd2:    d_code = 4;
                    3'd3:    d_code = 5;
                    3'd4:    d_code = 6;
                    3'd5:    d_code = (f7 == F7_ALT) ? 8 : 7;
                    3'd6:    d_code = 9;
                    default: d_code = 10;
                endcase
                d_ill = (f7 != 7'h00) && !((f7 == F7_ALT) && (f3 == 3'd0 || f3 == 3'd5));
            end
            OP_IMM: begin
                use_rs1 = 1'b1; wr_rd = 1'b1; d_imm = XLEN'(imm_i);
                case (f3)
                    3'd0:    d_code = 11;
                    3'd2:    d_code = 12;
                    3'd3:    d_code = 13;
                    3'd4:    d_code = 14;
                    3'd6:    d_code = 15;
                    3'd7:    d_code = 16;
                    3'd1:    d_code = 17;
                    default: d_code = (f7 == F7_ALT) ? 19 : 18;
                endcase
                d_ill = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                        ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != F7_ALT));
            end
            OP_LOAD: begin
                use_rs1 = 1'b1; wr_rd = 1'b1; is_load = 1'b1; d_dic = 2'd1; d_imm = XLEN'(imm_i);
                case (f3)
                    3'd0:    d_code = 20;
                    3'd1:    d_code = 21;
                    3'd2:    d_code = 22;
                    3'd4:    d_code = 23;
                    3'd5:    d_code = 24;
                    default: d_ill = 1'b1;
                endcase
            end
            OP_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; is_store = 1'b1; d_imm = XLEN'(imm_s);
                case (f3)
                    3'd0:    d_code = 25;
                    3'd1:    d_code = 26;
                    3'd2:    d_code = 27;
                    default: d_ill = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; is_branch = 1'b1; d_imm = XLEN'(imm_b);
                case (f3)
                    3'd0:    d_code = 28;
                    3'd1:    d_code = 29;
                    3'd4:    d_code = 30;
                    3'd5:    d_code = 31;
                    3'd6:    d_code = 32;
                    3'd7:    d_code = 33;
                    default: d_ill = 1'b1;
                endcase
            end
            OP_LUI: begin
                wr_rd = 1'b1; d_imm = XLEN'(imm_u); d_code = 34;
            end
            OP_AUIPC: begin
                wr_rd = 1'b1; d_imm = XLEN'(imm_u); d_dic = 2'd3; d_code = 35;
            end
            OP_JAL: begin
                wr_rd = 1'b1; is_jump = 1'b1; d_dic = 2'd2; d_imm = XLEN'(imm_j); d_code = 36;
            end
            OP_JALR: begin
                use_rs1 = 1'b1; wr_rd = 1'b1; is_jump = 1'b1; d_dic = 2'd2;
                d_imm = XLEN'(imm_i); d_code = 37; d_ill = (f3 != 3'd0);
            end
            default: d_ill = 1'b1;
        endcase
    end

    // x0 is never written even when the instruction names it as rd
    assign d_wr  = wr_rd && (ir[11:7] != 5'd0);
    assign state = st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= S_FETCH; ir <= '0; cnt <= '0;
            fetch_req <= 1'b0; read <= 1'b0; write <= 1'b0; funct3 <= '0;
            reg1 <= '0; reg2 <= '0; regd <= '0;
            en_read_1 <= 1'b0; en_read_2 <= 1'b0; en_write <= 1'b0;
            data_in_control <= '0; immediate <= '0; alu_control <= '0;
            jump <= 1'b0; branch_en <= 1'b0; pc_en <= 1'b0; trap <= 1'b0;
        end else begin
            fetch_req <= 1'b0; read <= 1'b0; write <= 1'b0; funct3 <= '0;
            en_read_1 <= 1'b0; en_read_2 <= 1'b0; en_write <= 1'b0;
            jump <= 1'b0; branch_en <= 1'b0; pc_en <= 1'b0;
            case (st)
                S_FETCH: begin
                    if (instr_ack) begin
                        ir <= instr_in; st <= S_DECODE;
                    end else begin
                        fetch_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (d_ill) begin
                        st <= S_TRAP; trap <= 1'b1;
                    end else begin
                        st <= S_EXECUTE;
                        reg1 <= use_rs1 ? ir[19:15] : 5'd0;
                        reg2 <= use_rs2 ? ir[24:20] : 5'd0;
                        regd <= wr_rd ? ir[11:7] : 5'd0;
                        data_in_control <= d_dic; immediate <= d_imm;
                        alu_control <= ALU_CTRL_W'(d_code);
                        en_read_1 <= use_rs1; en_read_2 <= use_rs2;
                        jump <= is_jump; branch_en <= is_branch;
                    end
                end
                S_EXECUTE: begin
                    if (is_load || is_store) begin
                        st <= S_MEMORY; read <= is_load; write <= is_store; funct3 <= f3;
                    end else begin
                        st <= S_WRITEBACK; en_write <= d_wr; pc_en <= 1'b1;
                    end
                end
                S_MEMORY: begin
                    if (mem_ack) begin
                        cnt <= '0; st <= S_WRITEBACK; en_write <= d_wr; pc_en <= 1'b1;
                    end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        cnt <= '0; st <= S_TRAP; trap <= 1'b1;
                        reg1 <= '0; reg2 <= '0; regd <= '0;
                        data_in_control <= '0; immediate <= '0; alu_control <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        read <= is_load; write <= is_store; funct3 <= f3;
                    end
                end
                S_WRITEBACK: begin
                    st <= S_FETCH; fetch_req <= 1'b1;
                    reg1 <= '0; reg2 <= '0; regd <= '0;
                    data_in_control <= '0; immediate <= '0; alu_control <= '0;
                end
                S_TRAP: trap <= 1'b1;
                default: begin
                    st <= S_TRAP; trap <= 1'b1;
                    reg1 <= '0; reg2 <= '0; regd <= '0;
                    data_in_control <= '0; immediate <= '0; alu_control <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_t08_mc_control_fsm.sv
// Bench for t08_mc_control_fsm: directed spec cases plus random instructions, every cycle's
// outputs compared against a table/arithmetic reference decoder.
module tb_t08_mc_control_fsm;
    localparam int MEM_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_ack = 1'b0;
    logic [31:0] instr_in = '0;
    logic        mem_ack = 1'b0;
    logic        fetch_req, read, write, en_read_1, en_read_2, en_write;
    logic        jump, branch_en, pc_en, trap;
    logic [2:0]  funct3, state;
    logic [4:0]  reg1, reg2, regd;
    logic [1:0]  data_in_control;
    logic [31:0] immediate;
    logic [5:0]  alu_control;

    int n_chk = 0;
    int n_fail = 0;

    t08_mc_control_fsm #(.XLEN(32), .ALU_CTRL_W(6), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .instr_ack(instr_ack), .instr_in(instr_in), .mem_ack(mem_ack),
        .fetch_req(fetch_req), .read(read), .write(write), .funct3(funct3),
        .reg1(reg1), .reg2(reg2), .regd(regd), .en_read_1(en_read_1), .en_read_2(en_read_2),
        .en_write(en_write), .data_in_control(data_in_control), .immediate(immediate),
        .alu_control(alu_control), .jump(jump), .branch_en(branch_en), .pc_en(pc_en),
        .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    logic [95:0] obs;
    assign obs = {25'b0, fetch_req, read, write, funct3, reg1, reg2, regd, en_read_1, en_read_2,
                  en_write, data_in_control, immediate, alu_control, jump, branch_en, pc_en,
                  trap, state};

    typedef struct {
        int          alu;
        logic [31:0] imm;
        logic [1:0]  dic;
        bit          r1, r2, wr, ld, st, jmp, br;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
    } ref_t;

    // ALU codes indexed by funct3 (R-type: +8 when funct7=0x20); 0 marks an illegal combination
    int r_tab[16]  = '{1, 3, 4, 5, 6, 7, 9, 10, 2, 0, 0, 0, 0, 8, 0, 0};
    int i_tab[8]   = '{11, 17, 12, 13, 14, 18, 15, 16};
    int ld_tab[8]  = '{20, 21, 22, 0, 23, 24, 0, 0};
    int st_tab[8]  = '{25, 26, 27, 0, 0, 0, 0, 0};
    int br_tab[8]  = '{28, 29, 0, 0, 30, 31, 32, 33};
    logic [6:0] op_tab[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic ref_t model(input logic [31:0] w);
        ref_t d;
        int v;
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        int imm_i = int'(w[31:20]) - (w[31] ? 4096 : 0);
        d = '{default: 0};
        d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7]; d.f3 = f3;
        case (op)
            7'h33: begin
                d.alu = r_tab[int'(f3) + ((f7 == 7'h20) ? 8 : 0)];
                if (f7 != 7'h00 && f7 != 7'h20) d.alu = 0;
                d.r1 = 1; d.r2 = 1; d.wr = 1;
            end
            7'h13: begin
                d.alu = i_tab[f3];
                if (f3 == 3'd1 && f7 != 7'h00) d.alu = 0;
                if (f3 == 3'd5) d.alu = (f7 == 7'h20) ? 19 : ((f7 == 7'h00) ? 18 : 0);
                d.imm = 32'(imm_i); d.r1 = 1; d.wr = 1;
            end
            7'h03: begin
                d.alu = ld_tab[f3]; d.imm = 32'(imm_i); d.r1 = 1; d.wr = 1; d.ld = 1; d.dic = 2'd1;
            end
            7'h23: begin
                v = int'(w[31:25]) * 32 + int'(w[11:7]) - (w[31] ? 4096 : 0);
                d.alu = st_tab[f3]; d.imm = 32'(v); d.r1 = 1; d.r2 = 1; d.st = 1;
            end
            7'h63: begin
                v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
                d.alu = br_tab[f3]; d.imm = 32'(v); d.r1 = 1; d.r2 = 1; d.br = 1;
            end
            7'h37: begin d.alu = 34; d.imm = {w[31:12], 12'h000}; d.wr = 1; end
            7'h17: begin d.alu = 35; d.imm = {w[31:12], 12'h000}; d.wr = 1; d.dic = 2'd3; end
            7'h6F: begin
                v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2
                    - (w[31] ? 1048576 : 0);
                d.alu = 36; d.imm = 32'(v); d.wr = 1; d.jmp = 1; d.dic = 2'd2;
            end
            7'h67: begin
                d.alu = (f3 == 3'd0) ? 37 : 0;
                d.imm = 32'(imm_i); d.r1 = 1; d.wr = 1; d.jmp = 1; d.dic = 2'd2;
            end
            default: d.alu = 0;
        endcase
        return d;
    endfunction

    // Expected output bundle for phase ph (0 FETCH .. 5 TRAP) given the decoded instruction.
    function automatic logic [95:0] expb(input int ph, input ref_t d);
        logic fq = 0, rd_s = 0, wr_s = 0, er1 = 0, er2 = 0, ew = 0, jp = 0, br = 0, pe = 0, tp = 0;
        logic [2:0]  f3 = 0;
        logic [4:0]  r1 = 0, r2 = 0, rdx = 0;
        logic [1:0]  dic = 0;
        logic [31:0] imm = 0;
        logic [5:0]  alu = 0;
        if (ph >= 2 && ph <= 4) begin
            r1 = d.r1 ? d.rs1 : 5'd0;
            r2 = d.r2 ? d.rs2 : 5'd0;
            rdx = d.wr ? d.rd : 5'd0;
            dic = d.dic; imm = d.imm; alu = 6'(d.alu);
        end
        case (ph)
            0: fq = 1;
            2: begin er1 = d.r1; er2 = d.r2; jp = d.jmp; br = d.br; end
            3: begin rd_s = d.ld; wr_s = d.st; f3 = d.f3; end
            4: begin ew = d.wr && (d.rd != 5'd0); pe = 1; end
            5: tp = 1;
            default: ;
        endcase
        return {25'b0, fq, rd_s, wr_s, f3, r1, r2, rdx, er1, er2, ew, dic, imm, alu,
                jp, br, pe, tp, 3'(ph)};
    endfunction

    task automatic noise();
        instr_ack = 1'($urandom_range(0, 1));
        instr_in  = $urandom;
        mem_ack   = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        reset = 1'b0; instr_ack = 1'b0; mem_ack = 1'b0;
        #1;
        chk("reset_async", obs, 96'h0);
        @(negedge clk);
        chk("reset_hold", obs, 96'h0);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Entered at a negedge with the DUT in FETCH; mwait=0 means mem_ack never comes.
    task automatic run_instr(input logic [31:0] w, input int fwait, input int mwait, input bit mid_rst);
        ref_t d = model(w);
        int lim;
        for (int i = 0; i <= fwait; i++) begin
            chk("fetch", obs, expb(0, d));
            instr_ack = (i == fwait);
            instr_in  = (i == fwait) ? w : $urandom;
            mem_ack   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("decode", obs, expb(1, d));
        noise();
        @(negedge clk);
        if (d.alu == 0) begin
            for (int i = 0; i < 3; i++) begin
                chk("trap_illegal", obs, expb(5, d));
                noise();
                @(negedge clk);
            end
            do_reset();
            return;
        end
        chk("execute", obs, expb(2, d));
        noise();
        @(negedge clk);
        if (d.ld || d.st) begin
            lim = (mwait == 0) ? MEM_TIMEOUT : mwait;
            for (int k = 1; k <= lim; k++) begin
                chk("memory", obs, expb(3, d));
                if (mid_rst && k == 2) begin
                    do_reset();
                    return;
                end
                mem_ack   = (mwait != 0 && k == mwait);
                instr_ack = 1'($urandom_range(0, 1));
                instr_in  = $urandom;
                @(negedge clk);
            end
            mem_ack = 1'b0;
            if (mwait == 0) begin
                for (int i = 0; i < 3; i++) begin
                    chk("trap_timeout", obs, expb(5, d));
                    noise();
                    @(negedge clk);
                end
                do_reset();
                return;
            end
        end
        chk("writeback", obs, expb(4, d));
        noise();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        int sel = $urandom_range(0, 10);
        if (sel < 9) w[6:0] = op_tab[sel];
        if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();
        run_instr(32'h002081B3, 0, 1, 1'b0);   // ADD x3,x1,x2
        run_instr(32'hFFF00093, 1, 1, 1'b0);   // ADDI x1,x0,-1
        run_instr(32'h00812283, 0, 3, 1'b0);   // LW x5,8(x2), ack on third MEMORY cycle
        run_instr(32'h001000EF, 2, 1, 1'b0);   // JAL x1,+2048
        run_instr(32'h00000013, 0, 1, 1'b0);   // NOP: rd=x0, no write strobe
        run_instr(32'hFE208EE3, 0, 1, 1'b0);   // BEQ x1,x2,-4
        run_instr(32'h00512223, 0, 0, 1'b0);   // SW x5,4(x2), no ack -> timeout trap
        run_instr(32'h0000007F, 0, 1, 1'b0);   // illegal opcode
        run_instr(32'h00812283, 1, 4, 1'b1);   // LW, reset pulse mid-MEMORY
        run_instr(32'h00512223, 0, 1, 1'b0);   // SW with immediate ack
        for (int n = 0; n < 250; n++)
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(1, 4), 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
